// File: rtl/rom_bus_pkg.sv
// Shared types and constants for the BIOS ROM bus front end.
package rom_bus_pkg;

  localparam int unsigned ROM_BANKS = 8;
  localparam int unsigned ROM_AW    = 13;
  localparam int unsigned SYS_AW    = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    DRIVE  = 2'd2
  } state_e;

  function automatic logic [ROM_BANKS-1:0] bank_to_cs_n(input logic [2:0] bank);
    logic [ROM_BANKS-1:0] cs_n;
    cs_n       = '1;
    cs_n[bank] = 1'b0;
    return cs_n;
  endfunction

endpackage

// File: rtl/rom_bus_ctrl_if.sv
// System-bus and ROM-side signals of rom_bus_ctrl; slave = controller, master = bus/ROM side.
interface rom_bus_ctrl_if;
  import rom_bus_pkg::*;

  logic                 ale;
  logic [SYS_AW-1:0]    addr_in;
  logic                 memr_n;
  logic [ROM_AW-1:0]    rom_a;
  logic [ROM_BANKS-1:0] rom_cs_n;
  logic [7:0]           rom_d;
  logic [7:0]           dbus_out;
  logic                 dbus_oe;
  logic                 ready;

  modport slave (
    input  ale, addr_in, memr_n, rom_d,
    output rom_a, rom_cs_n, dbus_out, dbus_oe, ready
  );

  modport master (
    output ale, addr_in, memr_n, rom_d,
    input  rom_a, rom_cs_n, dbus_out, dbus_oe, ready
  );
endinterface

// File: rtl/rom_wait_cnt.sv
// 4-bit loadable down-counter with zero flag; paces wait states in SELECT.
module rom_wait_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/rom_bus_ctrl.sv
// BIOS ROM bus front end: address latch, bank decode, wait-state insertion, read data drive.
// Optional running byte checksum enabled by defining ROM_CHECKSUM_EN.
module rom_bus_ctrl
  import rom_bus_pkg::*;
#(
  parameter logic [SYS_AW-1:0] BASE_ADDR   = 20'hF0000,
  parameter int unsigned       WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  rom_bus_ctrl_if.slave   bus
`ifdef ROM_CHECKSUM_EN
  ,
  input  logic            chk_clr,
  output logic [7:0]      checksum
`endif
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_e               state_q, state_d;
  logic [SYS_AW-1:0]    lat_addr_q, lat_addr_d;
  logic [ROM_AW-1:0]    rom_a_q, rom_a_d;
  logic [ROM_BANKS-1:0] cs_n_q, cs_n_d;
  logic [7:0]           dbus_q, dbus_d;
  logic                 cnt_load, cnt_dec, cnt_zero;
  logic                 hit;

  assign hit = (lat_addr_q[19:16] == BASE_ADDR[19:16]);

  // Bank and rom_a are captured into their own flops at trigger time, so a
  // later ALE only moves lat_addr and cannot disturb a cycle in progress.
  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    rom_a_d    = rom_a_q;
    cs_n_d     = cs_n_q;
    dbus_d     = dbus_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    if (bus.ale) begin
      lat_addr_d = bus.addr_in;
    end

    unique case (state_q)
      IDLE: begin
        if (!bus.memr_n && !bus.ale && hit) begin
          state_d  = SELECT;
          cs_n_d   = bank_to_cs_n(lat_addr_q[15:13]);
          rom_a_d  = lat_addr_q[ROM_AW-1:0];
          cnt_load = 1'b1;
        end
      end
      SELECT: begin
        if (bus.memr_n) begin
          state_d = IDLE;
          cs_n_d  = '1;
        end else if (cnt_zero) begin
          state_d = DRIVE;
          dbus_d  = bus.rom_d;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DRIVE: begin
        if (bus.memr_n) begin
          state_d = IDLE;
          cs_n_d  = '1;
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lat_addr_q <= '0;
      rom_a_q    <= '0;
      cs_n_q     <= '1;
      dbus_q     <= '0;
    end else begin
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      rom_a_q    <= rom_a_d;
      cs_n_q     <= cs_n_d;
      dbus_q     <= dbus_d;
    end
  end

  rom_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign bus.rom_a    = rom_a_q;
  assign bus.rom_cs_n = cs_n_q;
  assign bus.dbus_out = dbus_q;
  assign bus.dbus_oe  = (state_q == DRIVE);
  assign bus.ready    = (state_q != SELECT);

`ifdef ROM_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
  logic       capture;

  assign capture = (state_q == SELECT) && !bus.memr_n && cnt_zero;

  // A clear on a capture edge leaves just the captured byte.
  always_comb begin
    chk_d = (chk_clr ? 8'h00 : chk_q) + (capture ? bus.rom_d : 8'h00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign checksum = chk_q;
`endif

endmodule

// File: tb/tb_rom_bus_ctrl.sv
// Scoreboard bench for rom_bus_ctrl: reads push the image byte, a monitor checks each captured byte.
`timescale 1ns/1ps
module tb_rom_bus_ctrl;
  localparam int unsigned WS = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rom_bus_ctrl_if bus ();

`ifdef ROM_CHECKSUM_EN
  logic       chk_clr;
  logic [7:0] checksum;
`endif

  rom_bus_ctrl #(
    .BASE_ADDR   (20'hF0000),
    .WAIT_STATES (WS)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
`ifdef ROM_CHECKSUM_EN
    ,
    .chk_clr  (chk_clr),
    .checksum (checksum)
`endif
  );

  logic [7:0] img [0:65535];
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  logic oe_prev = 1'b0;

  // Eight-chip ROM model: the low chip select picks the bank.
  always_comb begin
    bus.rom_d = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (!bus.rom_cs_n[k]) bus.rom_d = img[{k[2:0], bus.rom_a}];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every rising dbus_oe is a capture and must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.dbus_oe === 1'b1 && oe_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_capture", 32'(bus.dbus_out), 32'hFFFF_FFFF);
      end else begin
        check("read_data", 32'(bus.dbus_out), 32'(exp_q.pop_front()));
      end
    end
    oe_prev = bus.dbus_oe;
  end

  task automatic do_read(input logic [19:0] a, input bit clr, input int hold);
    bit hit;
    int lowcnt;
    int n;
    logic [7:0] cs_exp;
    hit    = (a[19:16] == 4'hF);
    cs_exp = ~(8'h01 << a[15:13]);
    @(negedge clk);
    bus.ale = 1'b1; bus.addr_in = a; bus.memr_n = 1'b1;
    @(negedge clk);
    bus.ale = 1'b0; bus.memr_n = 1'b0;
    if (!hit) begin
      repeat (10) begin
        @(negedge clk);
        check("miss_cs", 32'(bus.rom_cs_n), 32'hFF);
        check("miss_ready", 32'(bus.ready), 32'd1);
        check("miss_oe", 32'(bus.dbus_oe), 32'd0);
      end
      bus.memr_n = 1'b1;
      return;
    end
    exp_q.push_back(img[a[15:0]]);
    @(negedge clk);
    check("sel_cs", 32'(bus.rom_cs_n), 32'(cs_exp));
    check("sel_rom_a", 32'(bus.rom_a), 32'(a[12:0]));
    lowcnt = 0;
    n = 0;
    while (bus.dbus_oe !== 1'b1 && n < 40) begin
      if (bus.ready === 1'b0) lowcnt++;
`ifdef ROM_CHECKSUM_EN
      if (lowcnt == WS + 1) chk_clr = clr;
`else
      if (clr && lowcnt < 0) lowcnt = 0;
`endif
      @(negedge clk);
      n++;
    end
`ifdef ROM_CHECKSUM_EN
    chk_clr = 1'b0;
`endif
    check("capture_seen", 32'(bus.dbus_oe), 32'd1);
    check("ready_low_clocks", 32'(lowcnt), 32'(WS + 1));
    repeat (hold) begin
      @(negedge clk);
      check("hold_oe", 32'(bus.dbus_oe), 32'd1);
      check("hold_cs", 32'(bus.rom_cs_n), 32'(cs_exp));
      check("hold_ready", 32'(bus.ready), 32'd1);
    end
    bus.memr_n = 1'b1;
    @(negedge clk);
    check("rel_cs", 32'(bus.rom_cs_n), 32'hFF);
    check("rel_oe", 32'(bus.dbus_oe), 32'd0);
  endtask

  initial begin
    int sum;
    for (int i = 0; i < 65536; i++) img[i] = 8'(i * 37 + (i >> 7)) ^ 8'hA5;
    img[16'hA123] = 8'h5A;
    img[16'h0100] = 8'h3C;
    for (int b = 0; b < 8; b++) begin
      sum = 0;
      for (int j = 0; j < 8191; j++) sum += int'(img[b * 8192 + j]);
      img[b * 8192 + 8191] = 8'(-sum);
    end

    reset_n = 1'b0; bus.ale = 1'b0; bus.addr_in = '0; bus.memr_n = 1'b1;
`ifdef ROM_CHECKSUM_EN
    chk_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_rom_a", 32'(bus.rom_a), 32'h0);
    check("rst_cs", 32'(bus.rom_cs_n), 32'hFF);
    check("rst_dbus", 32'(bus.dbus_out), 32'h0);
    check("rst_oe", 32'(bus.dbus_oe), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    reset_n = 1'b1;

    // Asynchronous reset in the middle of SELECT.
    @(negedge clk); bus.ale = 1'b1; bus.addr_in = 20'hF0004;
    @(negedge clk); bus.ale = 1'b0; bus.memr_n = 1'b0;
    @(negedge clk);
    check("mid_cs_low", 32'(bus.rom_cs_n), 32'hFE);
    repeat (2) @(negedge clk);
    check("mid_ready_low", 32'(bus.ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_cs", 32'(bus.rom_cs_n), 32'hFF);
    check("async_ready", 32'(bus.ready), 32'd1);
    check("async_oe", 32'(bus.dbus_oe), 32'd0);
    check("async_rom_a", 32'(bus.rom_a), 32'h0);
    @(negedge clk); bus.memr_n = 1'b1; reset_n = 1'b1;

    // Bank 5 hit with held strobe.
    do_read(20'hFA123, 1'b0, 3);
    check("b5_dbus_after", 32'(bus.dbus_out), 32'h5A);

    // Foreign cycle.
    do_read(20'hB8000, 1'b0, 0);

    // Abort while still waiting: no capture, data bus value kept.
    @(negedge clk); bus.ale = 1'b1; bus.addr_in = 20'hF0010;
    @(negedge clk); bus.ale = 1'b0; bus.memr_n = 1'b0;
    @(negedge clk);
    check("abort_ready_low", 32'(bus.ready), 32'd0);
    @(negedge clk); bus.memr_n = 1'b1;
    @(negedge clk);
    check("abort_cs", 32'(bus.rom_cs_n), 32'hFF);
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_oe", 32'(bus.dbus_oe), 32'd0);
    check("abort_dbus_kept", 32'(bus.dbus_out), 32'h5A);

    // Window sweep (strided) plus window edges.
    for (int a = 0; a < 65536; a += 31) do_read(20'hF0000 | 20'(a), 1'b0, 0);
    do_read(20'hF1FFF, 1'b0, 0);
    do_read(20'hF2000, 1'b0, 0);
    do_read(20'hFFFFF, 1'b0, 0);

`ifdef ROM_CHECKSUM_EN
    @(negedge clk); chk_clr = 1'b1;
    @(negedge clk); chk_clr = 1'b0;
    check("chk_cleared", 32'(checksum), 32'h00);
    for (int a = 16'hE000; a < 65536; a++) do_read(20'hF0000 | 20'(a), 1'b0, 0);
    check("chk_bank7", 32'(checksum), 32'h00);
    do_read(20'hF00FF, 1'b0, 0);
    do_read(20'hF0100, 1'b1, 0);
    check("chk_clr_capture", 32'(checksum), 32'h3C);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
